// File: rtl/ecc_pkg.sv
// Shared ECC accelerator definitions: field width and the state set
// reused by the modular add, subtract and multiply units.
package ecc_pkg;

    localparam int unsigned ECC_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        DIFF,
        CORR,
        DONE
    } sub_state_e;

endpackage

// File: rtl/ecc_alu.sv
// Combinational (WIDTH+1)-bit add/subtract ALU shared across one unit's
// FSM states: o_sum = i_x + (i_invert_y ? ~i_y : i_y) + i_carry.
module ecc_alu
    import ecc_pkg::*;
#(
    parameter int unsigned WIDTH = ECC_WIDTH
) (
    input  logic [WIDTH:0] i_x,
    input  logic [WIDTH:0] i_y,
    input  logic           i_invert_y,
    input  logic           i_carry,
    output logic [WIDTH:0] o_sum
);

    logic [WIDTH:0] w_y;

    always_comb begin
        w_y   = i_invert_y ? ~i_y : i_y;
        o_sum = i_x + w_y + {{WIDTH{1'b0}}, i_carry};
    end

endmodule

// File: rtl/sub_modular_unit.sv
// Multi-cycle modular subtractor: result_o = (A - B) mod P using one
// shared ALU over IDLE -> DIFF -> CORR -> DONE, all outputs registered.
module sub_modular_unit
    import ecc_pkg::*;
#(
    parameter int unsigned WIDTH = ECC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic             sub_start_i,
    output logic             busy_o,
    output logic             finish_o,
    output logic [WIDTH-1:0] result_o,
    output logic             range_err_o
);

    sub_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_range_err;

    logic [WIDTH:0]   w_alu_x;
    logic [WIDTH:0]   w_alu_y;
    logic             w_alu_inv;
    logic             w_alu_cin;
    logic [WIDTH:0]   w_alu_sum;
    logic             w_range_err;

    // DIFF forms a + ~b + 1 (borrow lands in the top bit); CORR adds p back.
    always_comb begin
        w_alu_x   = {1'b0, r_a};
        w_alu_y   = {1'b0, r_b};
        w_alu_inv = 1'b1;
        w_alu_cin = 1'b1;
        if (r_state == CORR) begin
            w_alu_x   = {1'b0, r_diff};
            w_alu_y   = {1'b0, r_p};
            w_alu_inv = 1'b0;
            w_alu_cin = 1'b0;
        end
        w_range_err = (r_a >= r_p) | (r_b >= r_p);
    end

    ecc_alu #(.WIDTH(WIDTH)) u_alu (
        .i_x        (w_alu_x),
        .i_y        (w_alu_y),
        .i_invert_y (w_alu_inv),
        .i_carry    (w_alu_cin),
        .o_sum      (w_alu_sum)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_range_err <= 1'b0;
            busy_o      <= 1'b0;
            finish_o    <= 1'b0;
            result_o    <= '0;
            range_err_o <= 1'b0;
        end else begin
            finish_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sub_start_i) begin
                        r_a         <= a_i;
                        r_b         <= b_i;
                        r_p         <= p_i;
                        range_err_o <= 1'b0;
                        busy_o      <= 1'b1;
                        r_state     <= DIFF;
                    end
                end
                DIFF: begin
                    r_diff      <= w_alu_sum[WIDTH-1:0];
                    r_borrow    <= w_alu_sum[WIDTH];
                    r_range_err <= w_range_err;
                    r_state     <= CORR;
                end
                CORR: begin
                    result_o <= r_borrow ? w_alu_sum[WIDTH-1:0] : r_diff;
                    busy_o   <= 1'b0;
                    r_state  <= DONE;
                end
                DONE: begin
                    finish_o    <= 1'b1;
                    range_err_o <= r_range_err;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
